// File: rtl/lzy_dff_ctrl_pkg.sv
// Shared op codes, FSM state encoding and width helpers for the shared 74HC74 bank controller.
package lzy_dff_ctrl_pkg;

  localparam logic [1:0] OP_CLR   = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_SHIFT = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_GRANT,
    ST_PULSE,
    ST_RECOV,
    ST_SETUP,
    ST_EDGE,
    ST_HOLD,
    ST_SAMPLE,
    ST_ACK
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  // Width of an index/counter covering v values, never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned v);
    return (clog2(v) == 0) ? 1 : clog2(v);
  endfunction

endpackage

// File: rtl/lzy_rr_arbiter.sv
// Round-robin arbiter: combinational winner search from the pointer, pointer advances past the winner on grant.
module lzy_rr_arbiter
  import lzy_dff_ctrl_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [NREQ-1:0]           i_req,
  input  logic                      i_grant,
  output logic                      o_valid_c,
  output logic [id_width(NREQ)-1:0] o_winner_c
);

  localparam int unsigned GW = id_width(NREQ);

  logic [GW-1:0] r_ptr;
  int unsigned   w_idx;

  // First set request at or after the pointer, wrapping around.
  always_comb begin
    o_valid_c  = 1'b0;
    o_winner_c = '0;
    w_idx      = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = 32'(r_ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!o_valid_c && i_req[GW'(w_idx)]) begin
        o_valid_c  = 1'b1;
        o_winner_c = GW'(w_idx);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_ptr <= '0;
    end else if (i_grant) begin
      r_ptr <= (32'(o_winner_c) == NREQ - 1) ? '0 : o_winner_c + GW'(1);
    end
  end

endmodule

// File: rtl/lzy_dff_seq_ctrl.sv
// Shares one bank of 74HC74 flip-flops between requesters: arbitrates, sequences
// clear/preset pulses or D/clock timing, then returns the bank's Q with a one-cycle Ack.
module lzy_dff_seq_ctrl
  import lzy_dff_ctrl_pkg::*;
#(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned REC_CYC   = 1
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [NREQ-1:0]           Req,
  input  logic [2*NREQ-1:0]         Op,
  input  logic [WIDTH*NREQ-1:0]     Wdata,
  output logic [NREQ-1:0]           Ack,
  output logic [WIDTH-1:0]          Rdata,
  output logic                      Busy,
  output logic [id_width(NREQ)-1:0] Grant_id,
  output logic [WIDTH-1:0]          Rd_n,
  output logic [WIDTH-1:0]          Sd_n,
  output logic [WIDTH-1:0]          Dout,
  output logic                      Dclk,
  input  logic [WIDTH-1:0]          Q_in
);

  localparam int unsigned GW = id_width(NREQ);
  localparam int unsigned CW = id_width((PULSE_CYC > REC_CYC) ? PULSE_CYC : REC_CYC);

  state_e           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_wdata;
  logic [GW-1:0]    r_gid;
  logic [NREQ-1:0]  r_ack, w_ack_nxt;
  logic [WIDTH-1:0] r_rdata;
  logic             r_busy;
  logic [WIDTH-1:0] r_rd_n, w_rd_n_nxt;
  logic [WIDTH-1:0] r_sd_n, w_sd_n_nxt;
  logic [WIDTH-1:0] r_dout, w_dout_nxt;
  logic             r_dclk, w_dclk_nxt;
  logic             w_grant;
  logic             w_arb_valid;
  logic [GW-1:0]    w_arb_win;

  lzy_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .Clk        (Clk),
    .Rst        (Rst),
    .i_req      (Req),
    .i_grant    (w_grant),
    .o_valid_c  (w_arb_valid),
    .o_winner_c (w_arb_win)
  );

  // Next state plus the pin values that go with it, so every output is registered.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_grant     = 1'b0;
    w_rd_n_nxt  = '1;
    w_sd_n_nxt  = '1;
    w_dout_nxt  = r_dout;
    w_dclk_nxt  = 1'b0;
    w_ack_nxt   = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_arb_valid) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        w_cnt_nxt = '0;
        if (r_op == OP_CLR || r_op == OP_SET) begin
          w_state_nxt = ST_PULSE;
        end else begin
          w_state_nxt = ST_SETUP;
          w_dout_nxt  = (r_op == OP_LOAD) ? r_wdata : {Q_in[WIDTH-2:0], r_wdata[0]};
        end
      end
      ST_PULSE: begin
        if (r_cnt == CW'(PULSE_CYC - 1)) begin
          w_state_nxt = ST_RECOV;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_RECOV: begin
        if (r_cnt == CW'(REC_CYC - 1)) begin
          w_state_nxt = ST_SAMPLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_SETUP:  w_state_nxt = ST_EDGE;
      ST_EDGE:   w_state_nxt = ST_HOLD;
      ST_HOLD:   w_state_nxt = ST_SAMPLE;
      ST_SAMPLE: w_state_nxt = ST_ACK;
      ST_ACK:    w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase

    // Clear and preset are mutually exclusive by construction: only one is chosen per op.
    if (w_state_nxt == ST_PULSE) begin
      if (r_op == OP_CLR) w_rd_n_nxt = '0;
      else                w_sd_n_nxt = '0;
    end
    w_dclk_nxt = (w_state_nxt == ST_EDGE);
    if (w_state_nxt == ST_ACK) w_ack_nxt[r_gid] = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_op    <= OP_CLR;
      r_wdata <= '0;
      r_gid   <= '0;
      r_ack   <= '0;
      r_rdata <= '0;
      r_busy  <= 1'b0;
      r_rd_n  <= '1;
      r_sd_n  <= '1;
      r_dout  <= '0;
      r_dclk  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ack   <= w_ack_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_rd_n  <= w_rd_n_nxt;
      r_sd_n  <= w_sd_n_nxt;
      r_dout  <= w_dout_nxt;
      r_dclk  <= w_dclk_nxt;
      if (w_grant) begin
        r_op    <= Op[32'(w_arb_win) * 2 +: 2];
        r_wdata <= Wdata[32'(w_arb_win) * WIDTH +: WIDTH];
        r_gid   <= w_arb_win;
      end
      if (r_state == ST_SAMPLE) r_rdata <= Q_in;
    end
  end

  assign Ack      = r_ack;
  assign Rdata    = r_rdata;
  assign Busy     = r_busy;
  assign Grant_id = r_gid;
  assign Rd_n     = r_rd_n;
  assign Sd_n     = r_sd_n;
  assign Dout     = r_dout;
  assign Dclk     = r_dclk;

endmodule

// File: tb/tb_lzy_dff_seq_ctrl.sv
// Bench for lzy_dff_seq_ctrl: behavioural 74HC74 bank on the pins, reference model of
// arbitration and bank contents feeding a scoreboard checked by an independent monitor.
module tb_lzy_dff_seq_ctrl;
  import lzy_dff_ctrl_pkg::*;

  localparam int unsigned NREQ = 2;
  localparam int unsigned W    = 4;
  localparam int unsigned PC   = 2;
  localparam int unsigned RC   = 1;
  localparam int unsigned GW   = id_width(NREQ);

  typedef struct {
    int         id;
    logic [W-1:0] rdata;
    int         lat;
    int         ndclk;
    int         nrd;
    int         nsd;
    bit         chk_dout;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] op;
  logic [W*NREQ-1:0] wdata;
  logic [NREQ-1:0]   ack;
  logic [W-1:0]      rdata;
  logic              busy;
  logic [GW-1:0]     gid;
  logic [W-1:0]      rd_n;
  logic [W-1:0]      sd_n;
  logic [W-1:0]      dout;
  logic              dclk;
  logic [W-1:0]      bank_q = '0;
  logic              dclk_prev = 1'b0;

  exp_t              sb_q[$];
  int                total = 0;
  int                bad = 0;
  int                ptr = 0;
  logic [W-1:0]      mq = '0;
  logic [NREQ-1:0]   req_at_edge = '0;
  logic              rst_at_edge = 1'b1;

  always #5 clk = ~clk;

  lzy_dff_seq_ctrl #(.NREQ(NREQ), .WIDTH(W), .PULSE_CYC(PC), .REC_CYC(RC)) dut (
    .Clk      (clk),
    .Rst      (rst),
    .Req      (req),
    .Op       (op),
    .Wdata    (wdata),
    .Ack      (ack),
    .Rdata    (rdata),
    .Busy     (busy),
    .Grant_id (gid),
    .Rd_n     (rd_n),
    .Sd_n     (sd_n),
    .Dout     (dout),
    .Dclk     (dclk),
    .Q_in     (bank_q)
  );

  // 74HC74 bank: async clear wins over preset, D captured on Dclk rising edge.
  always @(rd_n or sd_n or dclk) begin
    for (int i = 0; i < W; i++) begin
      if (rd_n[i] === 1'b0)                    bank_q[i] = 1'b0;
      else if (sd_n[i] === 1'b0)               bank_q[i] = 1'b1;
      else if (dclk === 1'b1 && !dclk_prev)    bank_q[i] = dout[i];
    end
    dclk_prev = (dclk === 1'b1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (p + k) % NREQ;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic set_req(input int r, input logic [1:0] o, input logic [W-1:0] d);
    req[r]          = 1'b1;
    op[2*r +: 2]    = o;
    wdata[W*r +: W] = d;
  endtask

  // Predict the winner and its result, queue it, then wait for its Ack.
  task automatic serve_one(output int w);
    exp_t         e;
    logic [1:0]   o;
    logic [W-1:0] d;
    bit           got;
    w = rr_pick(req, ptr);
    total++;
    if (w < 0) begin
      bad++;
      $display("FAIL serve: no request pending");
      w = 0;
      return;
    end
    o = op[2*w +: 2];
    d = wdata[W*w +: W];
    e.id = w; e.lat = 6; e.ndclk = 0; e.nrd = 0; e.nsd = 0; e.chk_dout = 1'b0;
    case (o)
      OP_CLR:  begin mq = '0; e.nrd = PC; e.lat = 3 + PC + RC; end
      OP_SET:  begin mq = '1; e.nsd = PC; e.lat = 3 + PC + RC; end
      OP_LOAD: begin mq = d; e.ndclk = 1; e.chk_dout = 1'b1; end
      default: begin mq = {mq[W-2:0], d[0]}; e.ndclk = 1; e.chk_dout = 1'b1; end
    endcase
    e.rdata = mq;
    sb_q.push_back(e);
    ptr = (w + 1) % NREQ;
    got = 1'b0;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      if (ack[w] === 1'b1) got = 1'b1;
    end
    if (!got) begin
      bad++;
      $display("FAIL ack_timeout: requester %0d got no ack, expected one", w);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      req_at_edge = req;
      rst_at_edge = rst;
    end
  end

  // Monitor: invariants every cycle, per-op counters, scoreboard pop on Ack.
  initial begin
    int              cyc, nd, nrd, nsd;
    logic [W-1:0]    dout_e;
    logic            prev_busy;
    logic [NREQ-1:0] prev_ack;
    logic [NREQ-1:0] ea;
    exp_t            e;
    cyc = 0; nd = 0; nrd = 0; nsd = 0; dout_e = '0; prev_busy = 1'b0; prev_ack = '0;
    forever begin
      @(negedge clk);
      if (rst_at_edge) begin
        cyc = 0; nd = 0; nrd = 0; nsd = 0;
        prev_busy = 1'b0; prev_ack = '0;
        continue;
      end
      chk("rd_sd_overlap", 32'(rd_n | sd_n), 32'({W{1'b1}}));
      if (dclk) chk("dclk_pins_idle", 32'({rd_n, sd_n}), 32'({2*W{1'b1}}));
      if (!prev_busy) chk("idle_to_grant", 32'(busy), 32'(req_at_edge != '0));
      if (prev_ack != '0) chk("idle_after_ack", 32'(busy), 32'(0));
      if (busy) begin
        cyc++;
        if (dclk) begin nd++; dout_e = dout; end
        if (rd_n != '1) nrd++;
        if (sd_n != '1) nsd++;
      end
      if (ack != '0) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_ack", 32'(ack), 32'(0));
        end else begin
          e  = sb_q.pop_front();
          ea = '0;
          ea[e.id] = 1'b1;
          chk("ack_vec",  32'(ack),   32'(ea));
          chk("grant_id", 32'(gid),   32'(e.id));
          chk("rdata",    32'(rdata), 32'(e.rdata));
          chk("latency",  32'(cyc),   32'(e.lat));
          chk("dclk_cyc", 32'(nd),    32'(e.ndclk));
          chk("rd_low",   32'(nrd),   32'(e.nrd));
          chk("sd_low",   32'(nsd),   32'(e.nsd));
          if (e.chk_dout) chk("dout_at_edge", 32'(dout_e), 32'(e.rdata));
        end
        cyc = 0; nd = 0; nrd = 0; nsd = 0;
      end
      prev_busy = busy;
      prev_ack  = ack;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int w;
    int cnt;
    rst = 1'b1; req = '0; op = '0; wdata = '0;
    set_req(0, OP_LOAD, 4'b1010);
    set_req(1, OP_CLR, W'($urandom));
    @(negedge clk);
    @(negedge clk);
    chk("rst_rd_n",  32'(rd_n),  32'({W{1'b1}}));
    chk("rst_sd_n",  32'(sd_n),  32'({W{1'b1}}));
    chk("rst_dout",  32'(dout),  32'(0));
    chk("rst_dclk",  32'(dclk),  32'(0));
    chk("rst_ack",   32'(ack),   32'(0));
    chk("rst_busy",  32'(busy),  32'(0));
    chk("rst_rdata", 32'(rdata), 32'(0));
    chk("rst_gid",   32'(gid),   32'(0));
    rst = 1'b0;

    serve_one(w); req[0] = 1'b0;
    serve_one(w); req[1] = 1'b0;
    set_req(0, OP_LOAD, 4'b1010);
    serve_one(w);
    set_req(0, OP_SHIFT, 4'b0001);
    serve_one(w);
    set_req(0, OP_SET, 4'b0000);
    serve_one(w); req[0] = 1'b0;

    set_req(0, OP_LOAD, 4'b0011);
    set_req(1, OP_LOAD, 4'b1100);
    for (int i = 0; i < 4; i++) serve_one(w);
    req = '0;

    for (int i = 0; i < 40; i++) begin
      for (int r = 0; r < NREQ; r++)
        if (!req[r] && $urandom_range(1, 0) == 1)
          set_req(r, 2'($urandom_range(3, 0)), W'($urandom));
      if (req == '0) set_req(int'($urandom_range(NREQ - 1, 0)), 2'($urandom_range(3, 0)), W'($urandom));
      serve_one(w);
      if ($urandom_range(1, 0) == 1) req[w] = 1'b0;
      else set_req(w, 2'($urandom_range(3, 0)), W'($urandom));
    end
    req = '0;
    repeat (3) @(negedge clk);

    // Abort a SET in its second pulse cycle.
    set_req(0, OP_SET, W'($urandom));
    cnt = 0;
    for (int c = 0; c < 20 && cnt < 2; c++) begin
      @(negedge clk);
      if (sd_n != '1) cnt++;
    end
    chk("abort_reached_pulse2", 32'(cnt), 32'(2));
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    chk("abort_sd_n", 32'(sd_n), 32'({W{1'b1}}));
    chk("abort_rd_n", 32'(rd_n), 32'({W{1'b1}}));
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_ack",  32'(ack),  32'(0));
    chk("abort_dclk", 32'(dclk), 32'(0));
    chk("abort_gid",  32'(gid),  32'(0));
    rst = 1'b0;
    ptr = 0;
    mq  = '1;

    set_req(0, OP_LOAD, W'($urandom));
    set_req(1, OP_LOAD, W'($urandom));
    serve_one(w);
    serve_one(w);
    req = '0;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
